// File: rtl/axi_stream_insert_header_mb.sv
// Prepends a multi-beat header to each AXI-Stream packet, byte-shifting the payload
// by the header's partial last beat; registered output, one beat per cycle.
module axi_stream_insert_header_mb #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      header_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic                    last_insert,
  output logic                    ready_insert,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  output logic                    hdr_err
);
  localparam int N = DATA_BYTE_WD;
  typedef enum logic [1:0] {IDLE, HDR, MERGE, TAIL} state_t;
  typedef logic [BYTE_CNT_WD-1:0] cnt_t;

  function automatic logic [N-1:0] top_ones(input cnt_t k);
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = (N - 1 - i) < int'(k);
    return m;
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [N-1:0] k);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < N; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  state_t             state, nxt_state;
  logic [DATA_WD-1:0] res, nxt_res;
  cnt_t               rcnt, nxt_rcnt;
  logic               nxt_valid, nxt_last, nxt_err;
  logic [DATA_WD-1:0] nxt_data;
  logic [N-1:0]       nxt_keep;
  logic               ld, hdr_hs, dat_hs, hdr_legal;
  logic [N-1:0]       keep_inc;
  cnt_t               hcnt, dcnt, sum;
  logic [DATA_WD-1:0] merged;

  assign ld           = !valid_out || ready_out;
  assign ready_insert = !rst && ld && (state == IDLE || state == HDR);
  assign ready_in     = !rst && ld && (state == MERGE);
  assign hdr_hs       = valid_insert && ready_insert;
  assign dat_hs       = valid_in && ready_in;

  // Legal last-header keep is 0..01..1: adding one clears every set bit.
  assign keep_inc  = keep_insert + N'(1);
  assign hdr_legal = (|keep_insert) && ((keep_insert & keep_inc) == '0);
  assign hcnt      = hdr_legal ? cnt_t'($countones(keep_insert)) : cnt_t'(N);
  assign dcnt      = cnt_t'($countones(keep_in));
  assign sum       = rcnt + dcnt;
  // Residual is kept MSB-aligned with zeroed low bytes, so merging is a plain OR.
  assign merged    = res | (data_in >> (8 * int'(rcnt)));

  always_comb begin
    nxt_state = state;
    nxt_res   = res;
    nxt_rcnt  = rcnt;
    nxt_valid = valid_out;
    nxt_data  = data_out;
    nxt_keep  = keep_out;
    nxt_last  = last_out;
    nxt_err   = 1'b0;
    if (ld) begin
      nxt_valid = 1'b0;
      nxt_data  = '0;
      nxt_keep  = '0;
      nxt_last  = 1'b0;
      case (state)
        IDLE, HDR: if (hdr_hs) begin
          if (!last_insert) begin
            nxt_valid = 1'b1;
            nxt_data  = header_insert;
            nxt_keep  = '1;
            nxt_state = HDR;
          end else begin
            nxt_err   = !hdr_legal;
            nxt_state = MERGE;
            if (hcnt == cnt_t'(N)) begin
              nxt_valid = 1'b1;
              nxt_data  = header_insert;
              nxt_keep  = '1;
              nxt_res   = '0;
              nxt_rcnt  = '0;
            end else begin
              nxt_res  = header_insert << (8 * (N - int'(hcnt)));
              nxt_rcnt = hcnt;
            end
          end
        end
        MERGE: if (dat_hs) begin
          nxt_valid = 1'b1;
          if (!last_in) begin
            nxt_data = merged;
            nxt_keep = '1;
            nxt_res  = data_in << (8 * (N - int'(rcnt)));
          end else if (sum <= cnt_t'(N)) begin
            nxt_data  = merged & byte_mask(top_ones(sum));
            nxt_keep  = top_ones(sum);
            nxt_last  = 1'b1;
            nxt_state = IDLE;
          end else begin
            nxt_data  = merged;
            nxt_keep  = '1;
            nxt_rcnt  = sum - cnt_t'(N);
            nxt_res   = (data_in << (8 * (N - int'(rcnt)))) & byte_mask(top_ones(sum - cnt_t'(N)));
            nxt_state = TAIL;
          end
        end
        TAIL: begin
          nxt_valid = 1'b1;
          nxt_data  = res;
          nxt_keep  = top_ones(rcnt);
          nxt_last  = 1'b1;
          nxt_res   = '0;
          nxt_rcnt  = '0;
          nxt_state = IDLE;
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      res       <= '0;
      rcnt      <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
      hdr_err   <= 1'b0;
    end else begin
      state     <= nxt_state;
      res       <= nxt_res;
      rcnt      <= nxt_rcnt;
      valid_out <= nxt_valid;
      data_out  <= nxt_data;
      keep_out  <= nxt_keep;
      last_out  <= nxt_last;
      hdr_err   <= nxt_err;
    end
  end
endmodule

// File: tb/tb_axi_stream_insert_header_mb.sv
// Directed vector bench for axi_stream_insert_header_mb at DATA_WD=32.
module tb_axi_stream_insert_header_mb;
  logic        clk = 0, rst = 1;
  logic        valid_in = 0, last_in = 0, ready_in;
  logic [31:0] data_in = 0;
  logic [3:0]  keep_in = 0;
  logic        valid_insert = 0, last_insert = 0, ready_insert;
  logic [31:0] header_insert = 0;
  logic [3:0]  keep_insert = 0;
  logic        valid_out, last_out, hdr_err, ready_out = 1;
  logic [31:0] data_out;
  logic [3:0]  keep_out;

  axi_stream_insert_header_mb #(.DATA_WD(32)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_insert(valid_insert), .header_insert(header_insert), .keep_insert(keep_insert),
    .last_insert(last_insert), .ready_insert(ready_insert),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out), .hdr_err(hdr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int nh; logic [3:0][31:0] h; logic [3:0][3:0] hk; logic [3:0] hl;
    int nd; logic [3:0][31:0] d; logic [3:0][3:0] dk; logic [3:0] dl;
    int no; logic [3:0][31:0] o; logic [3:0][3:0] ok; logic [3:0] ol;
    int err; bit stall; bit lat1; bit b2b;
  } vec_t;

  vec_t vecs[7];
  int cmp = 0, fails = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic hb(input int v, input logic [31:0] d, input logic [3:0] k, input logic l);
    vecs[v].h[vecs[v].nh] = d; vecs[v].hk[vecs[v].nh] = k; vecs[v].hl[vecs[v].nh] = l; vecs[v].nh++;
  endtask
  task automatic db(input int v, input logic [31:0] d, input logic [3:0] k, input logic l);
    vecs[v].d[vecs[v].nd] = d; vecs[v].dk[vecs[v].nd] = k; vecs[v].dl[vecs[v].nd] = l; vecs[v].nd++;
  endtask
  task automatic ob(input int v, input logic [31:0] d, input logic [3:0] k, input logic l);
    vecs[v].o[vecs[v].no] = d; vecs[v].ok[vecs[v].no] = k; vecs[v].ol[vecs[v].no] = l; vecs[v].no++;
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic run_vec(input vec_t v, input string name);
    int hi = 0, di = 0, oi = 0, cyc = 0, errs = 0, last_vis = -1;
    bit hold = 0, pend = 0, b2b_done = 0, h_acc, d_acc;
    logic [31:0] hd; logic [3:0] hk; logic hl;
    while (oi < v.no && cyc < 60) begin
      if (hi < v.nh) begin
        valid_insert = 1; header_insert = v.h[hi]; keep_insert = v.hk[hi]; last_insert = v.hl[hi];
      end else begin
        valid_insert = 0; header_insert = 0; keep_insert = 0; last_insert = 0;
      end
      if (di < v.nd) begin
        valid_in = 1; data_in = v.d[di]; keep_in = v.dk[di]; last_in = v.dl[di];
      end else begin
        valid_in = 0; data_in = 0; keep_in = 0; last_in = 0;
      end
      ready_out = v.stall ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (hdr_err) errs++;
      if (hold) begin
        chk($sformatf("%s stall data", name), data_out, hd);
        chk($sformatf("%s stall keep", name), {28'b0, keep_out}, {28'b0, hk});
        chk($sformatf("%s stall last", name), {31'b0, last_out}, {31'b0, hl});
      end
      if (pend && v.lat1) chk($sformatf("%s latency", name), {31'b0, valid_out}, 32'd1);
      if (valid_out && last_out && last_vis < 0) last_vis = cyc;
      h_acc = valid_insert && ready_insert;
      d_acc = valid_in && ready_in;
      if (h_acc && v.b2b && last_vis >= 0 && !b2b_done) begin
        chk($sformatf("%s b2b hdr cycle", name), cyc, last_vis);
        b2b_done = 1;
      end
      hold = valid_out && !ready_out;
      hd = data_out; hk = keep_out; hl = last_out;
      if (valid_out && ready_out) begin
        chk($sformatf("%s beat%0d data", name, oi), data_out, v.o[oi]);
        chk($sformatf("%s beat%0d keep", name, oi), {28'b0, keep_out}, {28'b0, v.ok[oi]});
        chk($sformatf("%s beat%0d last", name, oi), {31'b0, last_out}, {31'b0, v.ol[oi]});
        oi++;
      end
      pend = h_acc || d_acc;
      if (h_acc) hi++;
      if (d_acc) di++;
      @(negedge clk);
      cyc++;
    end
    if (oi < v.no) begin
      cmp++; fails++;
      $display("FAIL %s timeout: got %0d beats want %0d", name, oi, v.no);
    end
    valid_insert = 0; valid_in = 0; ready_out = 1;
    #1;
    if (hdr_err) errs++;
    chk($sformatf("%s no extra beat", name), {31'b0, valid_out}, 32'd0);
    chk($sformatf("%s hdr_err pulses", name), errs, v.err);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 7; i++) vecs[i] = '0;
    // case 1: 3-byte header, overflow into a tail beat
    hb(0, 32'h00AABBCC, 4'b0111, 1);
    db(0, 32'h11223344, 4'b1111, 0); db(0, 32'h55667788, 4'b1100, 1);
    ob(0, 32'hAABBCC11, 4'b1111, 0); ob(0, 32'h22334455, 4'b1111, 0); ob(0, 32'h66000000, 4'b1000, 1);
    // case 2: full header, partial data, 1-cycle latency
    hb(1, 32'hDEADBEEF, 4'b1111, 1); db(1, 32'h01020304, 4'b1110, 1);
    ob(1, 32'hDEADBEEF, 4'b1111, 0); ob(1, 32'h01020300, 4'b1110, 1);
    vecs[1].lat1 = 1;
    // case 3: two-beat header, exact fill, no tail
    hb(2, 32'hCAFEF00D, 4'b1111, 0); hb(2, 32'h0000ABCD, 4'b0011, 1);
    db(2, 32'h11223344, 4'b1100, 1);
    ob(2, 32'hCAFEF00D, 4'b1111, 0); ob(2, 32'hABCD1122, 4'b1111, 1);
    // case 4: case 1 under backpressure
    vecs[3] = vecs[0]; vecs[3].stall = 1;
    // case 5: back-to-back packets
    hb(4, 32'h00AABBCC, 4'b0111, 1); hb(4, 32'h0000DDEE, 4'b0011, 1);
    db(4, 32'h11223344, 4'b1000, 1); db(4, 32'h99887766, 4'b1111, 1);
    ob(4, 32'hAABBCC11, 4'b1111, 1); ob(4, 32'hDDEE9988, 4'b1111, 0); ob(4, 32'h77660000, 4'b1100, 1);
    vecs[4].b2b = 1;
    // case 6: non-contiguous header keep is treated as a full beat
    hb(5, 32'h12345678, 4'b0101, 1); db(5, 32'hA1B2C3D4, 4'b1000, 1);
    ob(5, 32'h12345678, 4'b1111, 0); ob(5, 32'hA1000000, 4'b1000, 1);
    vecs[5].err = 1;
    // empty last data beat: only the residual byte goes out, garbage data bytes masked
    hb(6, 32'h00000077, 4'b0001, 1); db(6, 32'hFFFFFFFF, 4'b0000, 1);
    ob(6, 32'h77000000, 4'b1000, 1);

    repeat (3) @(negedge clk);
    #1;
    chk("rst valid_out", {31'b0, valid_out}, 32'd0);
    chk("rst data_out", data_out, 32'd0);
    chk("rst keep_out", {28'b0, keep_out}, 32'd0);
    chk("rst last_out", {31'b0, last_out}, 32'd0);
    chk("rst hdr_err", {31'b0, hdr_err}, 32'd0);
    chk("rst ready_in", {31'b0, ready_in}, 32'd0);
    chk("rst ready_insert", {31'b0, ready_insert}, 32'd0);
    rst = 0;
    #1;
    chk("post-rst ready_insert", {31'b0, ready_insert}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // reset while in MERGE with a stalled output beat
    valid_insert = 1; header_insert = 32'hCAFEF00D; keep_insert = 4'b1111; last_insert = 1; ready_out = 0;
    #1;
    chk("mrst hdr accept", {31'b0, ready_insert}, 32'd1);
    @(negedge clk);
    valid_insert = 0;
    #1;
    chk("mrst valid held", {31'b0, valid_out}, 32'd1);
    rst = 1;
    #1;
    chk("mrst ready_in", {31'b0, ready_in}, 32'd0);
    chk("mrst ready_insert", {31'b0, ready_insert}, 32'd0);
    @(negedge clk);
    #1;
    chk("mrst valid_out", {31'b0, valid_out}, 32'd0);
    rst = 0; ready_out = 1;
    #1;
    chk("mrst ready_insert after", {31'b0, ready_insert}, 32'd1);
    @(negedge clk);
    run_vec(vecs[1], "recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end
endmodule
